// File: rtl/interpolator.sv
// Interpolator (up-sampler) for the DFE filter array.
// Each accepted input sample produces INTERPOLATION_FACTOR output samples at the
// clk_enable rate: the sample itself at phase 0, then zeros (zero-stuffing).
// Optional build macro INTERP_HOLD_EN: zero-order hold, where phases
// 1..INTERPOLATION_FACTOR-1 repeat the phase-0 sample instead of emitting zero.
module interpolator #(
  parameter int DATA_WIDTH           = 16,
  parameter int INTERPOLATION_FACTOR = 2,
  localparam int PHASE_WIDTH = (INTERPOLATION_FACTOR > 1) ? $clog2(INTERPOLATION_FACTOR) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clk_enable,
  input  logic signed [DATA_WIDTH-1:0]  interp_in,
  input  logic                          interp_in_valid,
  output logic                          interp_in_ready,
  output logic signed [DATA_WIDTH-1:0]  interp_out,
  output logic                          interp_out_valid,
  output logic [PHASE_WIDTH-1:0]        phase
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [PHASE_WIDTH-1:0] LAST_PHASE = PHASE_WIDTH'(INTERPOLATION_FACTOR - 1);
  localparam logic [PHASE_WIDTH-1:0] PHASE_ONE  = PHASE_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [PHASE_WIDTH-1:0]  phase_q, phase_d;
  logic [DATA_WIDTH-1:0]   out_q, out_d;
  logic                    out_valid_q, out_valid_d;
  logic                    accept;

  // Ready depends only on where we are in the burst: free when idle or on the last phase.
  always_comb begin
    interp_in_ready = (state_q == IDLE) || (phase_q == LAST_PHASE);
  end

  assign accept = interp_in_valid && interp_in_ready && clk_enable;

  // Next-state and next-output logic; everything holds when clk_enable is low.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (clk_enable) begin
      unique case (state_q)
        IDLE: begin
          phase_d = '0;
          if (accept) begin
            state_d     = RUN;
            out_d       = interp_in;
            out_valid_d = 1'b1;
          end else begin
            out_d       = '0;
            out_valid_d = 1'b0;
          end
        end
        RUN: begin
          if (phase_q != LAST_PHASE) begin
            // Mid-burst: keep streaming the stuffed (or held) samples.
            phase_d     = phase_q + PHASE_ONE;
            out_valid_d = 1'b1;
`ifdef INTERP_HOLD_EN
            out_d       = out_q;
`else
            out_d       = '0;
`endif
          end else if (accept) begin
            // Last phase with a new sample waiting: start the next burst with no bubble.
            phase_d     = '0;
            out_d       = interp_in;
            out_valid_d = 1'b1;
          end else begin
            state_d     = IDLE;
            phase_d     = '0;
            out_d       = '0;
            out_valid_d = 1'b0;
          end
        end
        default: begin
          state_d     = IDLE;
          phase_d     = '0;
          out_d       = '0;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset aborts any burst immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign interp_out       = out_q;
  assign interp_out_valid = out_valid_q;
  assign phase            = phase_q;

endmodule

// File: tb/tb_interpolator.sv
// Randomized scoreboard bench for interpolator, run on three factors (4, 3, 1) in parallel.
// Each accepted input pushes its whole expected burst into a queue; a monitor pops one
// entry per enabled output cycle and compares value, valid, phase and ready.
module tb_interpolator;

  typedef struct {
    logic [15:0] d;
    int          ph;
  } exp_t;

`ifdef INTERP_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk = 1'b0;
  int   total = 0;
  int   bad = 0;
  bit   done [3];

  always #5 clk = ~clk;

  task automatic check(input int lf, input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL L=%0d %s got=0x%0h want=0x%0h", lf, name, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int LF = (gi == 0) ? 4 : (gi == 1) ? 3 : 1;
    localparam int PW = (LF > 1) ? $clog2(LF) : 1;

    logic          rst_n;
    logic          en;
    logic [15:0]   din;
    logic          vin;
    logic          rdy;
    logic [15:0]   dout;
    logic          vout;
    logic [PW-1:0] ph;
    exp_t          q[$];
    bit            en_seen = 1'b0;

    interpolator #(
      .DATA_WIDTH(16),
      .INTERPOLATION_FACTOR(LF)
    ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .clk_enable(en),
      .interp_in(din),
      .interp_in_valid(vin),
      .interp_in_ready(rdy),
      .interp_out(dout),
      .interp_out_valid(vout),
      .phase(ph)
    );

    // One cycle of stimulus; the model accepts when no burst output is still pending.
    task automatic step(input bit v, input logic [15:0] d, input bit e, output bit acc);
      exp_t x;
      vin = v;
      din = d;
      en  = e;
      @(posedge clk);
      acc = v && e && rst_n && (q.size() == 0);
      if (acc) begin
        $display("L=%0d accept 0x%04h", LF, d);
        for (int k = 0; k < LF; k++) begin
          x.d  = (k == 0 || HOLD) ? d : 16'h0000;
          x.ph = k;
          q.push_back(x);
        end
      end
      #1;
    endtask

    // Present a sample and hold it until accepted (bounded).
    task automatic push_sample(input logic [15:0] d, input bit toggle);
      bit acc = 1'b0;
      bit e = 1'b1;
      int tries = 0;
      while (!acc && tries < 4 * LF + 8) begin
        step(1'b1, d, e, acc);
        if (toggle) e = !e;
        tries++;
      end
      if (!acc) check(LF, "accept_timeout", 0, 1);
      vin = 1'b0;
    endtask

    task automatic idle(input int n, input bit toggle);
      bit acc;
      bit e = 1'b1;
      for (int i = 0; i < n; i++) begin
        step(1'b0, 16'h0000, e, acc);
        if (toggle) e = !e;
      end
    endtask

    // Monitor: remembers whether the last edge was an enabled one.
    initial forever begin
      @(posedge clk);
      en_seen = en && rst_n;
    end

    // Monitor: on each negedge compare against the scoreboard (held values on disabled cycles).
    initial begin
      exp_t last;
      bit   last_v;
      last.d = 16'h0000;
      last.ph = 0;
      last_v = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          last.d = 16'h0000;
          last.ph = 0;
          last_v = 1'b0;
        end else begin
          if (en_seen) begin
            if (q.size() > 0) begin
              last = q.pop_front();
              last_v = 1'b1;
            end else begin
              last.d = 16'h0000;
              last.ph = 0;
              last_v = 1'b0;
            end
          end
          check(LF, "out_valid", int'(vout), int'(last_v));
          check(LF, "out", int'(dout), int'(last.d));
          check(LF, "phase", int'(ph), last.ph);
          check(LF, "ready", int'(rdy), int'(q.size() == 0));
        end
      end
    end

    // Stimulus sequence.
    initial begin
      bit          acc;
      bit          pend;
      logic [15:0] pd;
      rst_n = 1'b0;
      en    = 1'b0;
      vin   = 1'b0;
      din   = 16'h0000;
      #3;
      check(LF, "rst_ready", int'(rdy), 1);
      check(LF, "rst_out", int'(dout), 0);
      check(LF, "rst_valid", int'(vout), 0);
      check(LF, "rst_phase", int'(ph), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Single sample; the factor-3 instance runs with enable toggling every cycle.
      push_sample((LF == 3) ? 16'h8000 : 16'h1000, LF == 3);
      idle(2 * LF + 4, LF == 3);

      // Continuous valid: back-to-back bursts.
      if (LF == 1) begin
        for (int i = 1; i <= 8; i++) push_sample(16'(i), 1'b0);
      end else begin
        push_sample(16'h0100, 1'b0);
        push_sample(16'hFF00, 1'b0);
        push_sample(16'h7FFF, 1'b0);
      end
      idle(LF + 3, 1'b0);

      // Random valid/enable/data; upstream holds a pending sample until taken.
      pend = 1'b0;
      pd = 16'h0000;
      for (int i = 0; i < 250; i++) begin
        if (!pend && $urandom_range(0, 9) < 6) begin
          pend = 1'b1;
          pd = 16'($urandom);
        end
        step(pend, pend ? pd : 16'($urandom), $urandom_range(0, 9) < 7, acc);
        if (acc) pend = 1'b0;
      end
      vin = 1'b0;
      idle(LF + 3, 1'b0);

      // Reset asserted mid-burst (phase 2 where the factor allows).
      push_sample(16'h0123, 1'b0);
      for (int i = 0; i < ((LF - 1 < 2) ? LF - 1 : 2); i++) step(1'b0, 16'h0000, 1'b1, acc);
      rst_n = 1'b0;
      #1;
      q.delete();
      check(LF, "midrst_out", int'(dout), 0);
      check(LF, "midrst_valid", int'(vout), 0);
      check(LF, "midrst_phase", int'(ph), 0);
      check(LF, "midrst_ready", int'(rdy), 1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      push_sample(16'h0042, 1'b0);
      idle(LF + 3, 1'b0);
      done[gi] = 1'b1;
    end
  end

  // Wait for all instances (bounded), then report.
  initial begin
    bit all_done = 1'b0;
    for (int i = 0; i < 20000 && !all_done; i++) begin
      @(posedge clk);
      all_done = done[0] && done[1] && done[2];
    end
    if (!all_done) check(0, "global_timeout", 0, 1);
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interpolator.md
Name: interpolator

Overview:
- Up-sampler (interpolator) for the DFE filter array; the counterpart of the down-sampling decimator.
- Accepts one signed sample per input handshake.
- Emits INTERPOLATION_FACTOR output samples per input at the clk_enable rate: the input sample first, then zeros (zero-stuffing).
- Feeds the downstream anti-imaging FIR chain.

Parameters:
- DATA_WIDTH, 16, width of signed input and output samples (Q1.15 at default).
- INTERPOLATION_FACTOR, 2, output samples per input sample; legal range 1..256.
- PHASE_WIDTH, max(1, $clog2(INTERPOLATION_FACTOR)), localparam; width of the phase counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- clk_enable  input  1  output-rate strobe; all state advances only when high.
- interp_in  input  DATA_WIDTH  signed input sample.
- interp_in_valid  input  1  input sample present.
- interp_in_ready  output  1  block can take a sample this enabled cycle.
- interp_out  output  DATA_WIDTH  signed output sample, registered.
- interp_out_valid  output  1  interp_out holds a valid output-rate sample.
- phase  output  PHASE_WIDTH  index of the current output within its burst, 0..INTERPOLATION_FACTOR-1.

Behaviour:
- Reset is asynchronous, active-low, on rst_n, with clock clk. On reset:
  - state = IDLE.
  - interp_out = 0, interp_out_valid = 0, phase = 0.
  - interp_in_ready = 1.
- Accept condition: interp_in_valid & interp_in_ready & clk_enable. A sample is consumed only on an enabled cycle.
- interp_in_ready is combinational from state and phase:
  - 1 in IDLE.
  - 1 in RUN when phase == INTERPOLATION_FACTOR-1.
  - 0 otherwise.
  - Independent of clk_enable and of interp_in_valid.
- When clk_enable = 0, every register holds its value; interp_out_valid stays unchanged.
- State machine (all transitions evaluated on enabled cycles only):
  - IDLE, accept → RUN. Next cycle: interp_out = interp_in, phase = 0, interp_out_valid = 1.
  - IDLE, no accept → stay IDLE; interp_out = 0, interp_out_valid = 0.
  - RUN, phase < INTERPOLATION_FACTOR-1 → phase += 1; interp_out = 0; interp_out_valid = 1.
  - RUN, phase == INTERPOLATION_FACTOR-1, accept → stay RUN; phase = 0; interp_out = new sample. Back-to-back bursts have no bubble.
  - RUN, phase == INTERPOLATION_FACTOR-1, no accept → IDLE; interp_out = 0; interp_out_valid = 0; phase = 0.
- Latency: one enabled cycle from accept to the first output of the burst.
- Throughput: one input per INTERPOLATION_FACTOR enabled cycles.
- INTERPOLATION_FACTOR = 1:
  - Phase is always 0 and ready is always 1.
  - The block is a registered pass-through: out_valid follows the accept one enabled cycle later.
- Phase wraps from INTERPOLATION_FACTOR-1 to 0. It never exceeds INTERPOLATION_FACTOR-1, including for non-power-of-two factors.
- No arithmetic is applied: samples pass bit-exact, with no gain compensation and no width growth.
- interp_in_valid while ready = 0: the sample is not consumed. The upstream must hold it until accepted.
- Reset asserted mid-burst: the burst is aborted immediately (asynchronously). Outputs return to reset values. The first enabled cycle after release starts from IDLE.

Optional Feature:
- Macro INTERP_HOLD_EN.
- Defined: zero-order hold. Phases 1..INTERPOLATION_FACTOR-1 repeat the sample output at phase 0 instead of 0. Idle output still returns to 0.
- Undefined (default): zero-stuffing as described above.
- The macro has no effect on the handshake, state machine or timing.

Test Plan:
- L=4, single input 0x1000 with valid for one enabled cycle → outputs 0x1000, 0, 0, 0 with phase 0..3 and out_valid = 1 for 4 cycles; then out_valid = 0, out = 0.
- L=4, continuous valid with inputs 0x0100, 0xFF00, 0x7FFF → 12 consecutive valid outputs: 0x0100, 0, 0, 0, 0xFF00, 0, 0, 0, 0x7FFF, 0, 0, 0. ready is high only at phase 3 (and in initial IDLE).
- L=3, clk_enable toggling 1/0 each cycle, input 0x8000 → three valid outputs 0x8000, 0, 0 spread over 6 clocks; all state frozen on disabled cycles; phase never reaches 3.
- L=1, 8 samples 1..8 with continuous valid → outputs 1..8, each one enabled cycle after acceptance; ready constantly 1.
- L=4, rst_n asserted at phase 2 of a burst → out = 0, out_valid = 0, phase = 0, ready = 1 immediately; next accepted sample 0x0042 produces a fresh burst starting at phase 0.
- INTERP_HOLD_EN defined, L=4, input 0x1234 → outputs 0x1234 ×4, then idle output 0 with out_valid = 0.
